// File: rtl/instr_encoder.sv
// Instruction encoder / program loader.
// Packs field-level instruction requests into 16-bit words, queues them in a
// small FIFO and writes them into instruction memory from a base address.
// Optional feature macro: INSTR_ENC_CHECKSUM_EN (running 16-bit sum of written words).
module instr_encoder #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [3:0]        in_opcode,
    input  logic [2:0]        in_rd,
    input  logic [2:0]        in_rs,
    input  logic [2:0]        in_rt,
    input  logic [2:0]        in_funct,
    input  logic [5:0]        in_const,
    input  logic [8:0]        in_addr,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   wr_count,
    output logic              err,
    output logic [15:0]       csum
);

    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW   = PW + 1;
    localparam int unsigned CNTW = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state;
    logic [15:0]   fifo_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic [15:0]   packed_word;
    logic          legal;
    logic          accept;
    logic          push;
    logic          pop;
    logic [CW-1:0] count_nxt;
    logic [CW-1:0] remain;
    logic [PW-1:0] rd_nxt;
    logic [15:0]   head_nxt;

    // Field packing by instruction format; opcodes 13-15 are illegal
    always_comb begin
        packed_word = {in_funct, in_rt, in_rs, in_rd, in_opcode};
        legal       = 1'b1;
        case (in_opcode)
            4'd5, 4'd7:          packed_word = {in_const, in_rs, in_rd, in_opcode};
            4'd8:                packed_word = {in_const, in_rs, in_rt, in_opcode};
            4'd9:                packed_word = {in_funct, in_addr, in_opcode};
            4'd13, 4'd14, 4'd15: legal = 1'b0;
            default:             packed_word = {in_funct, in_rt, in_rs, in_rd, in_opcode};
        endcase
    end

    // Handshakes and next FIFO head; an empty queue bypasses the incoming word
    always_comb begin
        accept    = in_valid && in_ready && (state == S_RUN);
        push      = accept && legal;
        pop       = mem_we && mem_ready;
        count_nxt = count + CW'(push) - CW'(pop);
        remain    = count - CW'(pop);
        rd_nxt    = rd_ptr + PW'(pop);
        head_nxt  = (remain == '0) ? packed_word : fifo_mem[rd_nxt];
    end

    // FIFO storage; contents need no reset since count governs validity
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= packed_word;
        end
    end

    // Control FSM, FIFO pointers and registered write port
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wr_count  <= '0;
            err       <= 1'b0;
        end else begin
            count  <= count_nxt;
            rd_ptr <= rd_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            mem_we <= (count_nxt != '0);
            if (count_nxt != '0) begin
                mem_wdata <= head_nxt;
            end
            if (pop) begin
                mem_addr <= mem_addr + ADDR_W'(1);
                wr_count <= wr_count + CNTW'(1);
            end
            if (accept && !legal) begin
                err <= 1'b1;
            end
            done <= 1'b0;

            case (state)
                S_IDLE: begin
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    if (start) begin
                        state    <= S_RUN;
                        mem_addr <= base_addr;
                        wr_count <= '0;
                        err      <= 1'b0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    busy <= 1'b1;
                    if (accept && in_last) begin
                        state    <= S_DRAIN;
                        in_ready <= 1'b0;
                    end else begin
                        in_ready <= (count_nxt != CW'(DEPTH));
                    end
                end
                S_DRAIN: begin
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                    if (count == '0 && !mem_we) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

`ifdef INSTR_ENC_CHECKSUM_EN
    // Wrapping sum of every word accepted by memory during the current load
    always_ff @(posedge clk) begin
        if (rst) begin
            csum <= '0;
        end else if (state == S_IDLE && start) begin
            csum <= '0;
        end else if (pop) begin
            csum <= csum + mem_wdata;
        end
    end
`else
    assign csum = '0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [8:0]  base_addr;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [3:0]  in_opcode;
    logic [2:0]  in_rd, in_rs, in_rt, in_funct;
    logic [5:0]  in_const;
    logic [8:0]  in_addr;
    logic        mem_we;
    logic        mem_ready;
    logic [8:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        busy;
    logic        done;
    logic [9:0]  wr_count;
    logic        err;
    logic [15:0] csum;

    int n_checks = 0;
    int n_pass   = 0;

    logic [8:0]  log_addr [64];
    logic [15:0] log_data [64];
    int          log_n = 0;
    int          mark;
    logic [15:0] exp_csum;

    instr_encoder #(.ADDR_W(9), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
        .in_funct(in_funct), .in_const(in_const), .in_addr(in_addr),
        .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .wr_count(wr_count),
        .err(err), .csum(csum)
    );

    always #5 clk = ~clk;

    // Record every completed memory write
    always @(posedge clk) begin
        if (!rst && mem_we && mem_ready && log_n < 64) begin
            log_addr[log_n] <= mem_addr;
            log_data[log_n] <= mem_wdata;
            log_n           <= log_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic do_start(input logic [8:0] base);
        @(negedge clk);
        start     = 1'b1;
        base_addr = base;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic present(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                           input logic [2:0] rt, input logic [2:0] f, input logic [5:0] c,
                           input logic [8:0] a, input logic last);
        @(negedge clk);
        in_valid  = 1'b1;
        in_opcode = op;
        in_rd     = rd;
        in_rs     = rs;
        in_rt     = rt;
        in_funct  = f;
        in_const  = c;
        in_addr   = a;
        in_last   = last;
    endtask

    task automatic wait_accept(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(posedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) chk({tag, "_accept_timeout"}, 32'(ok), 32'd1);
    endtask

    task automatic send(input string tag, input logic [3:0] op, input logic [2:0] rd,
                        input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] f,
                        input logic [5:0] c, input logic [8:0] a, input logic last);
        present(op, rd, rs, rt, f, c, a, last);
        wait_accept(tag);
    endtask

    task automatic drop_valid();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 100 && !done; i++) @(negedge clk);
        chk({tag, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [8:0] a, input logic [15:0] d);
        chk({tag, "_addr"}, 32'(log_addr[idx]), 32'(a));
        chk({tag, "_data"}, 32'(log_data[idx]), 32'(d));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
        in_opcode = '0; in_rd = '0; in_rs = '0; in_rt = '0; in_funct = '0;
        in_const = '0; in_addr = '0; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_flags", {27'd0, in_ready, mem_we, busy, done, err}, 32'd0);
        chk("rst_wr_count", 32'(wr_count), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_csum", 32'(csum), 32'd0);
        rst = 1'b0;

        // Test 1: single I-format word
        mark = log_n;
        do_start(9'h010);
        chk("t1_busy_ready", {30'd0, busy, in_ready}, 32'd3);
        send("t1", 4'd5, 3'd3, 3'd2, 3'd0, 3'd0, 6'h2A, 9'h000, 1'b1);
        drop_valid();
        chk("t1_present", {15'd0, mem_we, mem_wdata}, {15'd0, 1'b1, 16'hA935});
        wait_done("t1");
        chk("t1_nwr", 32'(log_n - mark), 32'd1);
        chk_wr("t1_w0", mark, 9'h010, 16'hA935);
        chk("t1_wr_count", 32'(wr_count), 32'd1);
        @(negedge clk);
        chk("t1_done_pulse", {30'd0, done, busy}, 32'd0);

        // Test 2: R, store and jump formats
        mark = log_n;
        do_start(9'h020);
        send("t2a", 4'd1, 3'd1, 3'd2, 3'd3, 3'd0, 6'h00, 9'h000, 1'b0);
        send("t2b", 4'd8, 3'd0, 3'd1, 3'd5, 3'd0, 6'h04, 9'h000, 1'b0);
        send("t2c", 4'd9, 3'd0, 3'd0, 3'd0, 3'd0, 6'h00, 9'h1FF, 1'b1);
        drop_valid();
        wait_done("t2");
        chk("t2_nwr", 32'(log_n - mark), 32'd3);
        chk_wr("t2_w0", mark,     9'h020, 16'h0D11);
        chk_wr("t2_w1", mark + 1, 9'h021, 16'h10D8);
        chk_wr("t2_w2", mark + 2, 9'h022, 16'h1FF9);
        chk("t2_wr_count", 32'(wr_count), 32'd3);

        // Test 3: backpressure fills the FIFO at 4 words
        mark = log_n;
        do_start(9'h100);
        mem_ready = 1'b0;
        for (int i = 1; i <= 4; i++)
            send("t3_fill", 4'd2, 3'(i), 3'd0, 3'd0, 3'd0, 6'h00, 9'h000, 1'b0);
        present(4'd2, 3'd5, 3'd0, 3'd0, 3'd0, 6'h00, 9'h000, 1'b0);
        chk("t3_full_ready", 32'(in_ready), 32'd0);
        chk("t3_hold_a", {6'd0, mem_we, mem_addr, mem_wdata}, {6'd0, 1'b1, 9'h100, 16'h0012});
        repeat (3) @(negedge clk);
        chk("t3_hold_b", {6'd0, mem_we, in_ready, mem_addr, mem_wdata}, {6'd0, 2'b10, 9'h100, 16'h0012});
        chk("t3_no_wr", 32'(log_n - mark), 32'd0);
        mem_ready = 1'b1;
        wait_accept("t3_5");
        send("t3_6", 4'd2, 3'd6, 3'd0, 3'd0, 3'd0, 6'h00, 9'h000, 1'b1);
        drop_valid();
        wait_done("t3");
        chk("t3_nwr", 32'(log_n - mark), 32'd6);
        for (int i = 0; i < 6; i++)
            chk_wr("t3_w", mark + i, 9'(9'h100 + i), 16'((i + 1) * 16 + 2));
        chk("t3_wr_count", 32'(wr_count), 32'd6);

        // Test 4: address wrap
        mark = log_n;
        do_start(9'h1FF);
        send("t4a", 4'd5, 3'd3, 3'd2, 3'd0, 3'd0, 6'h2A, 9'h000, 1'b0);
        send("t4b", 4'd1, 3'd1, 3'd2, 3'd3, 3'd0, 6'h00, 9'h000, 1'b1);
        drop_valid();
        wait_done("t4");
        chk_wr("t4_w0", mark,     9'h1FF, 16'hA935);
        chk_wr("t4_w1", mark + 1, 9'h000, 16'h0D11);
        chk("t4_mem_addr", 32'(mem_addr), 32'h001);

        // Test 5: illegal opcode is dropped and flagged
        mark = log_n;
        do_start(9'h030);
        send("t5a", 4'd5, 3'd3, 3'd2, 3'd0, 3'd0, 6'h2A, 9'h000, 1'b0);
        send("t5b", 4'd14, 3'd7, 3'd7, 3'd7, 3'd7, 6'h3F, 9'h1FF, 1'b0);
        send("t5c", 4'd1, 3'd1, 3'd2, 3'd3, 3'd0, 6'h00, 9'h000, 1'b1);
        drop_valid();
        wait_done("t5");
        chk("t5_err", 32'(err), 32'd1);
        chk("t5_nwr", 32'(log_n - mark), 32'd2);
        chk_wr("t5_w1", mark + 1, 9'h031, 16'h0D11);
        chk("t5_wr_count", 32'(wr_count), 32'd2);

        // Test 6: reset in the middle of a load, then a clean load
        mark = log_n;
        do_start(9'h040);
        chk("t6_err_clr", 32'(err), 32'd0);
        mem_ready = 1'b0;
        for (int i = 1; i <= 4; i++)
            send("t6_fill", 4'd2, 3'(i), 3'd0, 3'd0, 3'd0, 6'h00, 9'h000, 1'b0);
        drop_valid();
        mem_ready = 1'b1;
        for (int i = 0; i < 50 && log_n < mark + 2; i++) @(negedge clk);
        rst       = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("t6_rst_flags", {28'd0, mem_we, busy, in_ready, done}, 32'd0);
        chk("t6_rst_count", 32'(wr_count), 32'd0);
        chk("t6_nwr", 32'(log_n - mark), 32'd2);
        rst       = 1'b0;
        mem_ready = 1'b1;
        mark = log_n;
        do_start(9'h050);
        send("t6a", 4'd5, 3'd3, 3'd2, 3'd0, 3'd0, 6'h2A, 9'h000, 1'b0);
        send("t6b", 4'd1, 3'd1, 3'd2, 3'd3, 3'd0, 6'h00, 9'h000, 1'b1);
        drop_valid();
        wait_done("t6");
        chk("t6_nwr2", 32'(log_n - mark), 32'd2);
        chk_wr("t6_w0", mark,     9'h050, 16'hA935);
        chk_wr("t6_w1", mark + 1, 9'h051, 16'h0D11);
`ifdef INSTR_ENC_CHECKSUM_EN
        exp_csum = 16'hB646;
`else
        exp_csum = 16'h0000;
`endif
        chk("t6_csum", 32'(csum), 32'(exp_csum));
        repeat (2) @(negedge clk);
        chk("t6_csum_hold", 32'(csum), 32'(exp_csum));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
